// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 16x2 text driver.
// Command bytes, FSM/write-phase encodings and a width helper.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_LINE,
    ST_FETCH,
    ST_WRITE
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ENABLE,
    PH_HOLD
  } wr_phase_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = FUNC_SET;
      2'd1:    cmd = DISP_ON;
      2'd2:    cmd = ENTRY;
      default: cmd = CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: setup, enable pulse, then post-write hold with rs/data frozen.
// done pulses one cycle before the wait ends; the idle cycle that follows is the last wait cycle.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned CLR_WAIT  = 100000,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned E_CYC     = 25,
  parameter int unsigned CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] wr_byte,
  input  logic       long_wait,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_CYC - 1);
  // Hold covers wait-1 cycles; the idle cycle after done completes the wait (wait >= 2).
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 2);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 2);

  wr_phase_t        phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_q;
  logic             load;
  logic [CNT_W-1:0] hold_last;

  assign hold_last = long_q ? CLR_LAST : CMD_LAST;
  assign lcd_en    = (phase == PH_ENABLE);

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    load      = 1'b0;
    done      = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) begin
          phase_nxt = PH_SETUP;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end
      PH_SETUP: begin
        if (cnt == SETUP_LAST) begin
          phase_nxt = PH_ENABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PH_ENABLE: begin
        if (cnt == E_LAST) begin
          phase_nxt = PH_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PH_HOLD: begin
        if (cnt == hold_last) begin
          phase_nxt = PH_IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        phase_nxt = PH_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        long_q   <= long_wait;
        lcd_rs   <= rs;
        lcd_data <= wr_byte;
      end
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-up init once, then endless refresh of 32 characters
// fetched from the upstream character source by index.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_WAIT  = 750000,
  parameter int unsigned CLR_WAIT  = 100000,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned E_CYC     = 25,
  parameter int unsigned CHAR_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int unsigned CNT_W = $clog2(max3(PWR_WAIT, CLR_WAIT, CMD_WAIT) + 1);
  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(CHAR_LAT - 1);

  lcd_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       index_nxt;
  logic [1:0]       step, step_nxt;
  logic             issued, issued_nxt;
  logic [7:0]       byte_q;
  logic             latch;
  logic             init_nxt;
  logic             frame_nxt;

  logic             wr_start;
  logic             wr_rs;
  logic [7:0]       wr_byte;
  logic             wr_long;
  logic             wr_done;

  assign lcd_rw = 1'b0;

  lcd_write_strobe #(
    .CLR_WAIT  (CLR_WAIT),
    .CMD_WAIT  (CMD_WAIT),
    .SETUP_CYC (SETUP_CYC),
    .E_CYC     (E_CYC),
    .CNT_W     (CNT_W)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .start     (wr_start),
    .rs        (wr_rs),
    .wr_byte   (wr_byte),
    .long_wait (wr_long),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (wr_done)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    index_nxt  = index;
    step_nxt   = step;
    issued_nxt = issued;
    latch      = 1'b0;
    init_nxt   = init_done;
    frame_nxt  = 1'b0;
    wr_start   = 1'b0;
    wr_rs      = 1'b0;
    wr_byte    = FUNC_SET;
    wr_long    = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (cnt == PWR_LAST) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_INIT: begin
        wr_byte = init_cmd(step);
        wr_long = (step == 2'd3);
        if (!issued) begin
          wr_start   = 1'b1;
          issued_nxt = 1'b1;
        end else if (wr_done) begin
          issued_nxt = 1'b0;
          if (step == 2'd3) begin
            step_nxt  = '0;
            init_nxt  = 1'b1;
            state_nxt = ST_LINE;
          end else begin
            step_nxt = step + 2'd1;
          end
        end
      end
      ST_LINE: begin
        wr_byte = index[4] ? LINE2 : LINE1;
        if (!issued) begin
          wr_start   = 1'b1;
          issued_nxt = 1'b1;
        end else if (wr_done) begin
          issued_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cnt == FETCH_LAST) begin
          latch     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_WRITE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WRITE: begin
        wr_rs   = 1'b1;
        wr_byte = byte_q;
        if (!issued) begin
          wr_start   = 1'b1;
          issued_nxt = 1'b1;
        end else if (wr_done) begin
          issued_nxt = 1'b0;
          cnt_nxt    = '0;
          if (index == 5'd15) begin
            index_nxt = 5'd16;
            state_nxt = ST_LINE;
          end else if (index == 5'd31) begin
            index_nxt = '0;
            frame_nxt = 1'b1;
            state_nxt = ST_LINE;
          end else begin
            index_nxt = index + 5'd1;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: begin
        state_nxt = ST_PWRUP;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PWRUP;
      cnt        <= '0;
      index      <= '0;
      step       <= '0;
      issued     <= 1'b0;
      byte_q     <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      index      <= index_nxt;
      step       <= step_nxt;
      issued     <= issued_nxt;
      init_done  <= init_nxt;
      frame_done <= frame_nxt;
      if (latch) byte_q <= char_in;
    end
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with shortened timing parameters.
module tb_lcd_text_driver;

  localparam int LIMIT = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  lcd_text_driver #(
    .PWR_WAIT  (20),
    .CLR_WAIT  (10),
    .CMD_WAIT  (4),
    .SETUP_CYC (1),
    .E_CYC     (2),
    .CHAR_LAT  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .index      (index),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Upstream model: ASCII 'A'+index, registered once; optionally scrambled while a write is in flight.
  logic [7:0] char_q = 8'h41;
  logic       tog = 1'b0;
  logic       scramble = 1'b0;
  int         since_fall = 0;

  always @(posedge clk) begin
    char_q     <= 8'h41 + {3'b000, index};
    tog        <= ~tog;
    since_fall <= lcd_en ? 0 : since_fall + 1;
  end

  always_comb begin
    char_in = char_q;
    if (scramble && (lcd_en || since_fall < 3)) char_in = char_q ^ (tog ? 8'hFF : 8'h55);
  end

  int fd_count = 0;
  int fd_wide  = 0;
  logic fd_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count <= fd_count + 1;
    if (frame_done === 1'b1 && fd_prev === 1'b1) fd_wide <= fd_wide + 1;
    fd_prev <= frame_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns after the falling edge of the next lcd_en pulse.
  task automatic get_byte(output logic rs_o, output logic [7:0] d_o, output int low_o,
                          output int high_o, output bit stable_o);
    logic       pr;
    logic [7:0] pd;
    int         low;
    int         high;
    pr = lcd_rs;
    pd = lcd_data;
    low = 0;
    high = 0;
    stable_o = 1'b1;
    while (lcd_en !== 1'b1 && low < LIMIT) begin
      pr = lcd_rs;
      pd = lcd_data;
      low++;
      @(negedge clk);
    end
    while (lcd_en === 1'b1 && high < LIMIT) begin
      if (lcd_rs !== pr || lcd_data !== pd) stable_o = 1'b0;
      high++;
      @(negedge clk);
    end
    rs_o   = pr;
    d_o    = pd;
    low_o  = low;
    high_o = high;
  endtask

  // exp_low < 0 skips the gap check (gap includes the post-write wait plus setup).
  task automatic expect_byte(input string tag, input logic exp_rs, input logic [7:0] exp_d,
                             input int exp_low);
    logic       rs_v;
    logic [7:0] d_v;
    int         low, high;
    bit         stable;
    get_byte(rs_v, d_v, low, high, stable);
    check({tag, " timeout"}, (low < LIMIT) ? 1 : 0, 1);
    check({tag, " rs"}, {31'd0, rs_v}, {31'd0, exp_rs});
    check({tag, " data"}, {24'd0, d_v}, {24'd0, exp_d});
    check({tag, " en_width"}, high, 2);
    check({tag, " stable"}, {31'd0, stable}, 1);
    check({tag, " rw"}, {31'd0, lcd_rw}, 0);
    if (exp_low >= 0) check({tag, " gap"}, low, exp_low);
  endtask

  task automatic expect_init(input string tag);
    logic       rs_v;
    logic [7:0] d_v;
    int         low, high;
    bit         stable;
    get_byte(rs_v, d_v, low, high, stable);
    check({tag, " pwrup_quiet"}, (low >= 20 && low < LIMIT) ? 1 : 0, 1);
    check({tag, " cmd0"}, {23'd0, rs_v, d_v}, {23'd0, 1'b0, 8'h38});
    check({tag, " cmd0 width"}, high, 2);
    expect_byte({tag, " cmd1"}, 1'b0, 8'h0C, 5);
    check({tag, " init_done early"}, {31'd0, init_done}, 0);
    expect_byte({tag, " cmd2"}, 1'b0, 8'h06, 5);
    expect_byte({tag, " cmd3"}, 1'b0, 8'h01, 5);
    check({tag, " init_done before wait"}, {31'd0, init_done}, 0);
    expect_byte({tag, " line1 after clear"}, 1'b0, 8'h80, 11);
    check({tag, " init_done"}, {31'd0, init_done}, 1);
  endtask

  function automatic logic [8:0] frame_entry(input int p);
    if (p == 0) return {1'b0, 8'h80};
    if (p <= 16) return {1'b1, 8'(8'h41 + p - 1)};
    if (p == 17) return {1'b0, 8'hC0};
    return {1'b1, 8'(8'h51 + p - 18)};
  endfunction

  initial begin
    logic [8:0] e;
    bit found;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst index", {27'd0, index}, 0);
    check("rst en", {31'd0, lcd_en}, 0);
    check("rst rs", {31'd0, lcd_rs}, 0);
    check("rst rw", {31'd0, lcd_rw}, 0);
    check("rst data", {24'd0, lcd_data}, 0);
    check("rst init_done", {31'd0, init_done}, 0);
    check("rst frame_done", {31'd0, frame_done}, 0);
    @(negedge clk);
    rst = 1'b0;

    expect_init("init");

    // Frame 1 line-1 command already consumed; walk three full frames.
    for (int f = 0; f < 3; f++) begin
      scramble = (f == 1);
      for (int p = 1; p < 34; p++) begin
        e = frame_entry(p);
        expect_byte($sformatf("f%0d p%0d", f, p), e[8], e[7:0], -1);
      end
      scramble = 1'b0;
      expect_byte($sformatf("f%0d wrap line1", f), 1'b0, 8'h80, -1);
      check($sformatf("f%0d frame_done count", f), fd_count, f + 1);
      check($sformatf("f%0d index wrapped", f), {27'd0, index}, 0);
    end
    check("frame_done width", fd_wide, 0);

    // Reset while the enable strobe for index 7 is high.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (lcd_en === 1'b1 && lcd_rs === 1'b1 && lcd_data === 8'h48) found = 1'b1;
      else @(negedge clk);
    end
    check("mid-write reached", {31'd0, found}, 1);
    check("mid-write index", {27'd0, index}, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst en", {31'd0, lcd_en}, 0);
    check("mid rst index", {27'd0, index}, 0);
    check("mid rst init_done", {31'd0, init_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_init("reinit");
    expect_byte("reinit A", 1'b1, 8'h41, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
